root_req_scheduler: RTL and testbench
=====================================

Name: root_req_scheduler

Overview:
- Upstream feeder for the n-th root engine.
- Accepts (radicand, degree) requests on a valid/ready stream and buffers them in a small FIFO.
- Issues requests to the root engine one at a time, holding the operands stable for the whole computation.
- Captures the single-cycle result pulse and presents it, tagged with a sequence ID, on a valid/ready output.

Parameters:
- DEPTH, 4, request FIFO entries (power of 2, >=2)
- TAG_W, 4, sequence tag width; tag wraps modulo 2^TAG_W
- TIMEOUT_CYCLES, 1023, watchdog limit (only with ROOT_SCHED_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO can accept
- req_radicand  in  10  radicand
- req_degree  in  3  root degree
- root_in_valid  out  1  one-cycle launch pulse to the root engine
- root_in_data_1  out  10  radicand to the engine, held until its result
- root_in_data_2  out  3  degree to the engine, held until its result
- root_rst_n  out  1  engine synchronous reset, active-low
- root_out_valid  in  1  engine result pulse
- root_out_data  in  20  engine result
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts
- res_data  out  20  result, unmodified engine value
- res_tag  out  TAG_W  sequence tag of the request
- res_err  out  1  1 = degree-0 reject or timeout
- busy  out  1  engine in use (LAUNCH or WAIT)

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; tag counter 0; state IDLE.
  - All outputs 0, except req_ready=1 and root_rst_n=0.
  - root_rst_n deasserts (1) on the first clock edge after rst falls.
- FIFO:
  - Push when req_valid & req_ready; req_ready = !full.
  - Pop only in IDLE on dispatch.
  - Simultaneous push and pop when full is not allowed (req_ready=0 when full).
  - Pointers wrap modulo DEPTH.
- Dispatch condition: state IDLE, FIFO non-empty, res_valid=0 (output slot free). The engine cannot be back-pressured, so no launch ever happens with the slot occupied.
- FSM:
  - IDLE:
    - Dispatch with degree==0: no launch; next cycle res_valid=1, res_data=0, res_err=1, res_tag=current tag; tag++; stay IDLE.
    - Dispatch with degree!=0: latch operands into root_in_data_1/2 -> LAUNCH.
  - LAUNCH: root_in_valid=1 for exactly this cycle -> WAIT.
  - WAIT:
    - root_in_data_1/2 held constant.
    - On root_out_valid: res_data<=root_out_data, res_err<=0, res_tag<=tag, res_valid<=1; tag++ -> IDLE.
    - root_out_valid outside WAIT is ignored.
- Output: res_* registered and stable while res_valid=1 & res_ready=0; res_valid clears on the handshake cycle.
- Dispatch slot-free check uses the registered res_valid, so back-to-back dispatch is not possible on the handshake cycle; one bubble is accepted.
- Latency: FIFO push to root_in_valid is 2 cycles minimum (push cycle, IDLE dispatch, LAUNCH). root_out_valid to res_valid is 1 cycle.
- busy=1 in LAUNCH and WAIT.
- Reset mid-operation: everything clears, pending requests are discarded, the engine is reset via root_rst_n.

Optional Feature:
- Macro ROOT_SCHED_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT (cleared on entering WAIT).
  - If it reaches TIMEOUT_CYCLES without root_out_valid: res_valid=1, res_data=0, res_err=1, tag++.
  - root_rst_n=0 for exactly one cycle to abort the engine, then -> IDLE.
  - A root_out_valid on the timeout cycle itself wins; the result is normal.
- When undefined: no counter, WAIT is unbounded, root_rst_n=0 only during/after reset as above.

Test Plan (behavioural engine stub answering after a programmable N cycles):
- Single request radicand=16, degree=2, stub N=30 returns 20'h01000 -> root_in_valid pulses once 2 cycles after push, operands held 16/2 for all 30 cycles, res_valid with res_data=20'h01000, res_tag=0, res_err=0.
- Push 5 requests with DEPTH=4 while engine busy -> req_ready drops after 4th accepted (5th retried), results emerge in order with tags 0..4.
- Degree 0 request (radicand=100) -> no root_in_valid; res_data=0, res_err=1 one cycle after dispatch.
- Hold res_ready=0 for 50 cycles with 2 queued requests -> second launch withheld until first result accepted; res_* stable throughout.
- Tag wrap: 17 requests with TAG_W=4 -> 17th result carries tag 0.
- With ROOT_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=20, stub never answers -> res_err=1 at cycle 20 of WAIT, root_rst_n low one cycle, next request dispatched normally.
- Assert rst mid-WAIT -> outputs reset immediately, FIFO empty, root_rst_n=0.

Source files
------------

// File: rtl/root_req_scheduler.sv
// Request FIFO and one-at-a-time dispatcher for the n-th root engine.
// Optional watchdog on the engine wait: define ROOT_SCHED_TIMEOUT_EN.
module root_req_scheduler #(
    parameter int DEPTH          = 4,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [9:0]       req_radicand,
    input  logic [2:0]       req_degree,
    output logic             root_in_valid,
    output logic [9:0]       root_in_data_1,
    output logic [2:0]       root_in_data_2,
    output logic             root_rst_n,
    input  logic             root_out_valid,
    input  logic [19:0]      root_out_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [19:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [9:0]       r_fifo_rad [DEPTH];
    logic [2:0]       r_fifo_deg [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [9:0]       r_op_rad;
    logic [2:0]       r_op_deg;
    logic             r_root_rst_n;
    logic             r_res_valid;
    logic [19:0]      r_res_data;
    logic [TAG_W-1:0] r_res_tag;
    logic             r_res_err;
    logic [TAG_W-1:0] r_tag;

    logic       w_empty;
    logic       w_full;
    logic       w_push;
    logic       w_dispatch;
    logic       w_zero;
    logic       w_go;
    logic       w_done;
    logic       w_timeout;
    logic [9:0] w_head_rad;
    logic [2:0] w_head_deg;

    // Extra pointer bit distinguishes full from empty.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = req_valid && !w_full;

    assign w_head_rad = r_fifo_rad[r_rd_ptr[AW-1:0]];
    assign w_head_deg = r_fifo_deg[r_rd_ptr[AW-1:0]];

    // The engine cannot stall, so never launch into an occupied slot.
    assign w_dispatch = (r_state == S_IDLE) && !w_empty && !r_res_valid;
    assign w_zero     = w_dispatch && (w_head_deg == 3'd0);
    assign w_go       = w_dispatch && (w_head_deg != 3'd0);
    assign w_done     = (r_state == S_WAIT) && root_out_valid;

`ifdef ROOT_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_wd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt <= '0;
        end else if (r_state == S_LAUNCH) begin
            r_wd_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    // A result arriving on the limit cycle takes priority.
    assign w_timeout = (r_state == S_WAIT) && !root_out_valid &&
                       (r_wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rad[r_wr_ptr[AW-1:0]] <= req_radicand;
            r_fifo_deg[r_wr_ptr[AW-1:0]] <= req_degree;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_dispatch) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        root_in_valid = 1'b0;
        busy          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                root_in_valid = 1'b1;
                busy          = 1'b1;
                w_state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (w_done || w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_rad     <= '0;
            r_op_deg     <= '0;
            r_root_rst_n <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_tag    <= '0;
            r_res_err    <= 1'b0;
            r_tag        <= '0;
        end else begin
            r_root_rst_n <= !w_timeout;
            if (w_go) begin
                r_op_rad <= w_head_rad;
                r_op_deg <= w_head_deg;
            end
            if (w_done) begin
                r_res_valid <= 1'b1;
                r_res_data  <= root_out_data;
                r_res_err   <= 1'b0;
                r_res_tag   <= r_tag;
                r_tag       <= r_tag + 1'b1;
            end else if (w_zero || w_timeout) begin
                r_res_valid <= 1'b1;
                r_res_data  <= '0;
                r_res_err   <= 1'b1;
                r_res_tag   <= r_tag;
                r_tag       <= r_tag + 1'b1;
            end else if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign req_ready      = !w_full;
    assign root_in_data_1 = r_op_rad;
    assign root_in_data_2 = r_op_deg;
    assign root_rst_n     = r_root_rst_n;
    assign res_valid      = r_res_valid;
    assign res_data       = r_res_data;
    assign res_tag        = r_res_tag;
    assign res_err        = r_res_err;

endmodule

// File: tb/tb_root_req_scheduler.sv
// Directed bench for root_req_scheduler with a behavioural root engine stub.
// Default build (no watchdog).
module tb_root_req_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [9:0]  req_radicand = '0;
    logic [2:0]  req_degree = '0;
    logic        root_in_valid;
    logic [9:0]  root_in_data_1;
    logic [2:0]  root_in_data_2;
    logic        root_rst_n;
    logic        root_out_valid;
    logic [19:0] root_out_data;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [19:0] res_data;
    logic [3:0]  res_tag;
    logic        res_err;
    logic        busy;

    always #5 clk = ~clk;

    root_req_scheduler #(
        .DEPTH(4),
        .TAG_W(4),
        .TIMEOUT_CYCLES(1023)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_radicand(req_radicand),
        .req_degree(req_degree),
        .root_in_valid(root_in_valid),
        .root_in_data_1(root_in_data_1),
        .root_in_data_2(root_in_data_2),
        .root_rst_n(root_rst_n),
        .root_out_valid(root_out_valid),
        .root_out_data(root_out_data),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_tag(res_tag),
        .res_err(res_err),
        .busy(busy)
    );

    // Engine stub: answers stub_n cycles after the launch pulse.
    int          stub_n = 1;
    logic [19:0] stub_data = '0;
    bit          stub_echo = 1'b0;
    int          s_cnt = 0;
    bit          s_busy = 1'b0;
    logic [9:0]  s_rad = '0;
    logic [2:0]  s_deg = '0;
    int          s_launch = 0;
    int          hold_err = 0;
    logic        s_out_v = 1'b0;
    logic [19:0] s_out_d = '0;

    assign root_out_valid = s_out_v;
    assign root_out_data  = s_out_d;

    function automatic logic [19:0] echo(input logic [9:0] r, input logic [2:0] d);
        return {4'hA, 3'b000, d, r};
    endfunction

    always @(posedge clk) begin
        if (!root_rst_n) begin
            s_cnt   <= 0;
            s_busy  <= 1'b0;
            s_out_v <= 1'b0;
        end else begin
            s_out_v <= 1'b0;
            if (root_in_valid) begin
                s_busy   <= 1'b1;
                s_cnt    <= stub_n;
                s_rad    <= root_in_data_1;
                s_deg    <= root_in_data_2;
                s_launch <= s_launch + 1;
            end else if (s_busy) begin
                if (root_in_data_1 != s_rad || root_in_data_2 != s_deg)
                    hold_err <= hold_err + 1;
                if (s_cnt <= 1) begin
                    s_busy  <= 1'b0;
                    s_out_v <= 1'b1;
                    s_out_d <= stub_echo ? echo(s_rad, s_deg) : stub_data;
                end else begin
                    s_cnt <= s_cnt - 1;
                end
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] exp_tag = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [9:0] r, input logic [2:0] d);
        int k;
        k = 0;
        req_valid    = 1'b1;
        req_radicand = r;
        req_degree   = d;
        while (!req_ready && k < 300) begin
            tick();
            k++;
        end
        chk("push_wait_bound", 32'(k < 300), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_res(input string nm);
        int k;
        k = 0;
        while (!res_valid && k < 500) begin
            tick();
            k++;
        end
        if (k >= 500) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: res_valid never rose within 500 cycles", nm);
        end
    endtask

    task automatic check_res(input string nm, input logic [19:0] d, input logic e);
        chk({nm, "_data"}, 32'(res_data), 32'(d));
        chk({nm, "_err"}, 32'(res_err), 32'(e));
        chk({nm, "_tag"}, 32'(res_tag), 32'(exp_tag));
        exp_tag = exp_tag + 4'd1;
    endtask

    task automatic take();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    typedef struct {
        logic [9:0]  rad;
        logic [2:0]  deg;
        int          n;
        logic [19:0] rsp;
        logic [19:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t tbl[6];

    initial begin : watchdog
        #400000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        int k;
        int l0;
        int h0;
        int bad;
        logic [19:0] cap_d;
        logic [3:0]  cap_t;
        logic        cap_e;
        logic [9:0]  f_rad[6];
        logic [2:0]  f_deg[6];

        tbl[0] = '{10'd16,   3'd2, 30, 20'h01000, 20'h01000, 1'b0};
        tbl[1] = '{10'd100,  3'd0, 5,  20'hFFFFF, 20'h00000, 1'b1};
        tbl[2] = '{10'd1023, 3'd7, 1,  20'hABCDE, 20'hABCDE, 1'b0};
        tbl[3] = '{10'd0,    3'd1, 3,  20'h00000, 20'h00000, 1'b0};
        tbl[4] = '{10'd729,  3'd3, 12, 20'h00009, 20'h00009, 1'b0};
        tbl[5] = '{10'd500,  3'd0, 2,  20'h12345, 20'h00000, 1'b1};

        #1 rst = 1'b1;
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_root_rst_n", 32'(root_rst_n), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_root_in_valid", 32'(root_in_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_fields", 32'({res_data, res_tag, res_err}), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_rst_n_low", 32'(root_rst_n), 32'd0);
        tick();
        chk("rst_release_rst_n_high", 32'(root_rst_n), 32'd1);

        // Single requests, one at a time.
        for (int v = 0; v < 6; v++) begin
            stub_echo = 1'b0;
            stub_n    = tbl[v].n;
            stub_data = tbl[v].rsp;
            l0 = s_launch;
            req_valid    = 1'b1;
            req_radicand = tbl[v].rad;
            req_degree   = tbl[v].deg;
            tick();
            req_valid = 1'b0;
            k = 1;
            if (tbl[v].deg != 3'd0) begin
                while (!root_in_valid && k < 10) begin
                    tick();
                    k++;
                end
                chk("launch_latency", 32'(k), 32'd2);
                chk("launch_op1", 32'(root_in_data_1), 32'(tbl[v].rad));
                chk("launch_op2", 32'(root_in_data_2), 32'(tbl[v].deg));
                chk("launch_busy", 32'(busy), 32'd1);
                h0 = hold_err;
                wait_res("vec_res");
                chk("operand_hold", 32'(hold_err - h0), 32'd0);
            end else begin
                while (!res_valid && k < 10) begin
                    tick();
                    k++;
                end
                chk("reject_latency", 32'(k), 32'd2);
            end
            check_res("vec", tbl[v].exp_d, tbl[v].exp_e);
            chk("vec_launches", 32'(s_launch - l0), 32'(tbl[v].deg != 3'd0));
            take();
            chk("vec_res_clear", 32'(res_valid), 32'd0);
        end

        // Fill the FIFO while the engine is busy.
        stub_echo = 1'b1;
        stub_n    = 20;
        f_rad = '{10'd1, 10'd100, 10'd101, 10'd102, 10'd103, 10'd200};
        f_deg = '{3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        push1(f_rad[0], f_deg[0]);
        k = 0;
        while (!busy && k < 10) begin
            tick();
            k++;
        end
        chk("fifo_engine_busy", 32'(busy), 32'd1);
        for (int i = 1; i < 5; i++) begin
            req_valid    = 1'b1;
            req_radicand = f_rad[i];
            req_degree   = f_deg[i];
            chk("fifo_accept", 32'(req_ready), 32'd1);
            tick();
        end
        req_radicand = f_rad[5];
        req_degree   = f_deg[5];
        chk("fifo_full_ready", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        for (int j = 0; j < 6; j++) begin
            wait_res("fifo_res");
            check_res("fifo_order", echo(f_rad[j], f_deg[j]), 1'b0);
            take();
            if (j == 0) push1(f_rad[5], f_deg[5]);
        end

        // Output back-pressure withholds the next launch.
        stub_n = 5;
        push1(10'd300, 3'd3);
        push1(10'd301, 3'd6);
        wait_res("bp_first");
        check_res("bp_first", echo(10'd300, 3'd3), 1'b0);
        cap_d = res_data;
        cap_t = res_tag;
        cap_e = res_err;
        l0  = s_launch;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (!res_valid || res_data != cap_d || res_tag != cap_t ||
                res_err != cap_e || root_in_valid || busy)
                bad++;
        end
        chk("bp_stable", 32'(bad), 32'd0);
        chk("bp_no_launch", 32'(s_launch - l0), 32'd0);
        take();
        k = 1;
        while (!root_in_valid && k < 10) begin
            tick();
            k++;
        end
        chk("bp_relaunch_latency", 32'(k), 32'd2);
        wait_res("bp_second");
        check_res("bp_second", echo(10'd301, 3'd6), 1'b0);
        take();

        // Reset while the engine is working, with one request queued.
        stub_n = 40;
        push1(10'd400, 3'd2);
        push1(10'd401, 3'd3);
        for (int c = 0; c < 10; c++) tick();
        chk("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_root_rst_n", 32'(root_rst_n), 32'd0);
        chk("midrst_res_valid", 32'(res_valid), 32'd0);
        chk("midrst_ops", 32'({root_in_data_1, root_in_data_2}), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_rst_n_back", 32'(root_rst_n), 32'd1);
        exp_tag = '0;
        l0 = s_launch;
        for (int c = 0; c < 60; c++) tick();
        chk("midrst_fifo_flushed", 32'(s_launch - l0), 32'd0);
        chk("midrst_no_result", 32'(res_valid), 32'd0);

        // Tag wrap over 17 results.
        stub_n = 1;
        for (int i = 0; i < 17; i++) begin
            push1(10'(i), (i % 4 == 0) ? 3'd0 : 3'd1);
            wait_res("wrap_res");
            if (i % 4 == 0)
                check_res("wrap", 20'h00000, 1'b1);
            else
                check_res("wrap", echo(10'(i), 3'd1), 1'b0);
            if (i == 16) chk("wrap_tag17", 32'(res_tag), 32'd0);
            take();
        end

        chk("hold_total", 32'(hold_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
